// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall sequencer: FSM state encoding,
// the zero-register constant and the per-stage enable/flush bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-side view of the stall sequencer: hazard inputs, memory
// handshake and the enable/flush lines feeding the pipeline registers.
interface pipe_stall_ctrl_if;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_Rt;
  logic [4:0] IFID_Rs;
  logic [4:0] IFID_Rt;
  logic       EX_BranchTaken;
  logic       EXMEM_MemRead;
  logic       EXMEM_MemWrite;
  logic       dmem_ack;
  logic       PC_WriteEn;
  logic       IFID_WriteEn;
  logic       IDEX_WriteEn;
  logic       EXMEM_WriteEn;
  logic       MEMWB_WriteEn;
  logic       IFID_Flush;
  logic       IDEX_Flush;
  logic       dmem_req;
  logic       mem_err;

  // Pipeline / memory side
  modport master (
    output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, EX_BranchTaken,
           EXMEM_MemRead, EXMEM_MemWrite, dmem_ack,
    input  PC_WriteEn, IFID_WriteEn, IDEX_WriteEn, EXMEM_WriteEn, MEMWB_WriteEn,
           IFID_Flush, IDEX_Flush, dmem_req, mem_err
  );

  // Stall controller side
  modport slave (
    input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, EX_BranchTaken,
           EXMEM_MemRead, EXMEM_MemWrite, dmem_ack,
    output PC_WriteEn, IFID_WriteEn, IDEX_WriteEn, EXMEM_WriteEn, MEMWB_WriteEn,
           IFID_Flush, IDEX_Flush, dmem_req, mem_err
  );
endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is a
// source of the instruction in ID (register zero never creates a hazard).
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  output logic       load_use_o
);

  assign load_use_o = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline (Mealy FSM RUN/MEM_WAIT/ERR).
// Define PIPE_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stall_ctrl_if.slave     bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
`endif
);

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_ERR      = ERR;
  localparam int         WCNT_W     = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              load_use;
  logic              mem_op;
  logic              req;
  stage_ctrl_t       ctrl;

  hazard_detect u_hazard_detect (
    .idex_memread_i (bus.IDEX_MemRead),
    .idex_rt_i      (bus.IDEX_Rt),
    .ifid_rs_i      (bus.IFID_Rs),
    .ifid_rt_i      (bus.IFID_Rt),
    .load_use_o     (load_use)
  );

  // Unfrozen pipeline: a taken branch squashes ID, so it overrides load-use.
  function automatic stage_ctrl_t run_ctrl(input logic branch, input logic lu);
    stage_ctrl_t c;
    c = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1, memwb_we: 1'b1,
          ifid_flush: 1'b0, idex_flush: 1'b0};
    if (branch) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (lu) begin
      c.pc_we      = 1'b0;
      c.ifid_we    = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

  assign mem_op = bus.EXMEM_MemRead | bus.EXMEM_MemWrite;

  always_comb begin
    ctrl    = '0;
    req     = 1'b0;
    state_d = state_q;
    wait_d  = wait_q;
    if (!rst) begin
      case (state_q)
        S_RUN: begin
          req = mem_op;
          if (mem_op && !bus.dmem_ack) begin
            state_d = S_MEM_WAIT;
            wait_d  = WCNT_W'(1);
          end else begin
            ctrl = run_ctrl(bus.EX_BranchTaken, load_use);
          end
        end
        S_MEM_WAIT: begin
          req = 1'b1;
          if (bus.dmem_ack) begin
            // Frozen inputs are still valid, so hazards are evaluated on the ack cycle.
            ctrl    = run_ctrl(bus.EX_BranchTaken, load_use);
            state_d = S_RUN;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
            if (wait_q == WCNT_W'(MEM_TIMEOUT - 1)) state_d = S_ERR;
          end
        end
        S_ERR: ;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.PC_WriteEn    = ctrl.pc_we;
  assign bus.IFID_WriteEn  = ctrl.ifid_we;
  assign bus.IDEX_WriteEn  = ctrl.idex_we;
  assign bus.EXMEM_WriteEn = ctrl.exmem_we;
  assign bus.MEMWB_WriteEn = ctrl.memwb_we;
  assign bus.IFID_Flush    = ctrl.ifid_flush;
  assign bus.IDEX_Flush    = ctrl.idex_flush;
  assign bus.dmem_req      = req;
  assign bus.mem_err       = (state_q == S_ERR) && !rst;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.pc_we && (state_q != S_ERR) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if ((ctrl.ifid_flush || ctrl.idex_flush) && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = rst ? '0 : stall_q;
  assign flush_events = rst ? '0 : flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios then random
// traffic, all compared against a behavioural request-age model.
module tb_pipe_stall_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  pipe_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: how long the current memory request has been outstanding.
  int m_age   = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  bit         i_mr, i_br, i_emr, i_emw, i_ack, i_rst;
  logic [4:0] i_rt, i_rs, i_rt2;

  // Expected {PC,IFID,IDEX,EXMEM,MEMWB WriteEn, IFID,IDEX Flush, dmem_req, mem_err}
  function automatic logic [8:0] model_out();
    bit lu, busy;
    lu   = i_mr && (i_rt != 5'd0) && (i_rt == i_rs || i_rt == i_rt2);
    busy = (m_age > 0) || i_emr || i_emw;
    if (i_rst)           return 9'b0;
    if (m_err)           return 9'b0_0000_0001;
    if (busy && !i_ack)  return 9'b0_0000_0010;
    if (i_br)            return {5'b11111, 2'b11, busy, 1'b0};
    if (lu)              return {5'b00111, 2'b01, busy, 1'b0};
    return {5'b11111, 2'b00, busy, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] rt2, input bit br, input bit emr,
                        input bit emw, input bit ack, input bit r);
    i_mr = mr; i_rt = rt; i_rs = rs; i_rt2 = rt2; i_br = br;
    i_emr = emr; i_emw = emw; i_ack = ack; i_rst = r;
  endtask

  task automatic step(input string tag);
    logic [8:0] exp, obs;
    bit frozen;
    rst                = i_rst;
    bus.IDEX_MemRead   = i_mr;
    bus.IDEX_Rt        = i_rt;
    bus.IFID_Rs        = i_rs;
    bus.IFID_Rt        = i_rt2;
    bus.EX_BranchTaken = i_br;
    bus.EXMEM_MemRead  = i_emr;
    bus.EXMEM_MemWrite = i_emw;
    bus.dmem_ack       = i_ack;
    #3;
    exp = model_out();
    obs = {bus.PC_WriteEn, bus.IFID_WriteEn, bus.IDEX_WriteEn, bus.EXMEM_WriteEn,
           bus.MEMWB_WriteEn, bus.IFID_Flush, bus.IDEX_Flush, bus.dmem_req, bus.mem_err};
    $display("[%0t] %-12s rst=%0b mr=%0b rt=%0d rs=%0d rt2=%0d br=%0b mem=%0b%0b ack=%0b -> out=%b exp=%b",
             $time, tag, i_rst, i_mr, i_rt, i_rs, i_rt2, i_br, i_emr, i_emw, i_ack, obs, exp);
    check(tag, 16'(obs), 16'(exp));
`ifdef PIPE_PERF_CNT_EN
    check({tag, "_stall"}, 16'(stall_cycles), i_rst ? 16'd0 : 16'(m_stall));
    check({tag, "_flush"}, 16'(flush_events), i_rst ? 16'd0 : 16'(m_flush));
`endif
    @(posedge clk);
    frozen = !i_rst && !m_err && ((m_age > 0) || i_emr || i_emw) && !i_ack;
    if (i_rst) begin
      m_age = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else if (!m_err) begin
      if (!exp[8] && m_stall < SAT) m_stall++;
      if ((exp[3] || exp[2]) && m_flush < SAT) m_flush++;
      if (frozen) begin
        if (m_age == TMO - 1) begin m_err = 1'b1; m_age = 0; end
        else m_age++;
      end else begin
        m_age = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    step("reset0");
    step("reset1");

    set_in(1, 8, 8, 3, 0, 0, 0, 0, 0);  step("lu_stall");
    set_in(0, 0, 8, 3, 0, 0, 0, 0, 0);  step("lu_after");
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);  step("rt_zero");
    set_in(1, 8, 8, 0, 1, 0, 0, 0, 0);  step("br_over_lu");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("stray_ack");

    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("mem_wait");
    i_ack = 1; step("mem_ack");
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);  step("zero_wait");

    set_in(1, 5, 5, 0, 0, 1, 0, 0, 0);  step("mem_over_lu");
    i_ack = 1;                          step("lu_on_ack");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("idle");

    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) step("timeout");
    i_ack = 1;                          step("err_sticky");
    i_rst = 1;                          step("err_rst");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("post_err");

    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("pre_rst_w0");
    step("pre_rst_w1");
    i_rst = 1;                          step("rst_midwait");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("after_rst");

    for (int n = 0; n < 600; n++) begin
      if (m_age > 0) begin
        i_ack = ($urandom_range(0, 2) == 0);
      end else begin
        set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b0);
      end
      i_rst = ($urandom_range(0, 59) == 0);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
